// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and constants for the MEM-stage access unit.
//   - WB_FROM_* : write-back source selector encodings
//   - mem_state_e : access FSM state encoding
//   - is_misaligned() : word-alignment test on the low address bits
package mem_access_pkg;

    localparam int DATA_W = 32;
    localparam int PC_W   = 16;

    localparam logic [1:0] WB_FROM_NOP = 2'd0;
    localparam logic [1:0] WB_FROM_ALU = 2'd1;
    localparam logic [1:0] WB_FROM_MEM = 2'd2;
    localparam logic [1:0] WB_FROM_PC4 = 2'd3;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_e;

    // Word accesses only: any set bit in addr[1:0] is a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_wb_sel.sv
// mem_wb_sel: combinational write-back source mux.
//   wb_sel     : source selector (WB_FROM_*)
//   alu_result : ALU value / memory address
//   rdata      : data-memory read data
//   pc4        : PC+4, zero-extended to DATA_W
//   wb_data    : selected write-back value (zero for WB_FROM_NOP)
module mem_wb_sel
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 16
) (
    input  logic [1:0]        wb_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] rdata,
    input  logic [PC_W-1:0]   pc4,
    output logic [DATA_W-1:0] wb_data
);

    // Select the write-back value.
    always_comb begin
        wb_data = '0;
        case (wb_sel)
            WB_FROM_ALU: wb_data = alu_result;
            WB_FROM_MEM: wb_data = rdata;
            WB_FROM_PC4: wb_data = DATA_W'(pc4);
            default:     wb_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM-stage data-memory access unit.
//   Inputs from EX/MEM: inst_valid_i, mem_wen_i, mem_wdata_i, reg_wen_i,
//     reg_waddr_i, alu_result_i (address or ALU value), wb_sel_i, pc_i, pc4_i.
//   pause_o: combinational stall request while a bus access is outstanding.
//   Data bus: dmem_req_o/we_o/addr_o/wdata_o out, dmem_gnt_i/rvalid_i/rdata_i in.
//   MEM/WB record (registered): wb_valid_o, reg_wen_o, reg_waddr_o, wb_data_o,
//     pc_o, misalign_o.
//   rst is asynchronous, active-low.
// EX/MEM flushes to a bubble while paused, so a memory instruction is copied
// into local latches on acceptance and the access runs only from that copy.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid_i,
    input  logic              mem_wen_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              reg_wen_i,
    input  logic [4:0]        reg_waddr_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [1:0]        wb_sel_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [PC_W-1:0]   pc4_i,
    output logic              pause_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              wb_valid_o,
    output logic              reg_wen_o,
    output logic [4:0]        reg_waddr_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              misalign_o
);

    mem_state_e        state_r, state_nxt_s;

    logic              memop_s, misalign_s, accept_s;

    logic [DATA_W-1:0] lat_addr_r, lat_wdata_r;
    logic              lat_we_r, lat_reg_wen_r;
    logic [4:0]        lat_waddr_r;
    logic [1:0]        lat_wb_sel_r;
    logic [PC_W-1:0]   lat_pc_r, lat_pc4_r;

    logic              pause_s, rec_valid_s, rec_reg_wen_s, rec_misalign_s;
    logic [4:0]        rec_waddr_s;
    logic [PC_W-1:0]   rec_pc_s, mux_pc4_s;
    logic [1:0]        mux_sel_s;
    logic [DATA_W-1:0] mux_alu_s, mux_data_s;

    logic              wb_valid_r, reg_wen_out_r, misalign_r;
    logic [4:0]        reg_waddr_out_r;
    logic [DATA_W-1:0] wb_data_r;
    logic [PC_W-1:0]   pc_out_r;

    assign memop_s    = inst_valid_i & (mem_wen_i | (wb_sel_i == WB_FROM_MEM));
    assign misalign_s = is_misaligned(alu_result_i[1:0]);
    assign accept_s   = (state_r == MEM_IDLE) & memop_s & ~misalign_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= MEM_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state, stall request and the write-back record to be registered.
    // Outside IDLE every record field comes from the latched copy.
    always_comb begin
        state_nxt_s    = state_r;
        pause_s        = 1'b0;
        rec_valid_s    = 1'b0;
        rec_reg_wen_s  = 1'b0;
        rec_misalign_s = 1'b0;
        rec_waddr_s    = lat_waddr_r;
        rec_pc_s       = lat_pc_r;
        mux_sel_s      = lat_wb_sel_r;
        mux_alu_s      = lat_addr_r;
        mux_pc4_s      = lat_pc4_r;
        case (state_r)
            MEM_IDLE: begin
                rec_waddr_s = reg_waddr_i;
                rec_pc_s    = pc_i;
                mux_alu_s   = alu_result_i;
                mux_pc4_s   = pc4_i;
                if (memop_s && !misalign_s) begin
                    state_nxt_s = MEM_REQ;
                    pause_s     = 1'b1;
                end else if (memop_s) begin
                    // Misaligned: retire immediately with no register write.
                    rec_valid_s    = 1'b1;
                    rec_misalign_s = 1'b1;
                    mux_sel_s      = WB_FROM_ALU;
                end else begin
                    // Non-memory ops write back PC+4 or the ALU value only.
                    rec_valid_s   = inst_valid_i;
                    rec_reg_wen_s = reg_wen_i & inst_valid_i;
                    mux_sel_s     = (wb_sel_i == WB_FROM_PC4) ? WB_FROM_PC4 : WB_FROM_ALU;
                end
            end
            MEM_REQ: begin
                pause_s = 1'b1;
                if (dmem_gnt_i && lat_we_r) begin
                    state_nxt_s   = MEM_IDLE;
                    pause_s       = 1'b0;
                    rec_valid_s   = 1'b1;
                    rec_reg_wen_s = lat_reg_wen_r;
                end else if (dmem_gnt_i) begin
                    state_nxt_s = MEM_RESP;
                end else begin
                    state_nxt_s = MEM_REQ;
                end
            end
            MEM_RESP: begin
                pause_s = 1'b1;
                if (dmem_rvalid_i) begin
                    state_nxt_s   = MEM_IDLE;
                    pause_s       = 1'b0;
                    rec_valid_s   = 1'b1;
                    rec_reg_wen_s = lat_reg_wen_r;
                    mux_sel_s     = WB_FROM_MEM;
                end else begin
                    state_nxt_s = MEM_RESP;
                end
            end
            default: begin
                state_nxt_s = MEM_IDLE;
            end
        endcase
    end

    // Capture the accepted memory instruction; upstream is flushed afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_addr_r    <= '0;
            lat_wdata_r   <= '0;
            lat_we_r      <= 1'b0;
            lat_reg_wen_r <= 1'b0;
            lat_waddr_r   <= 5'd0;
            lat_wb_sel_r  <= WB_FROM_NOP;
            lat_pc_r      <= '0;
            lat_pc4_r     <= '0;
        end else if (accept_s) begin
            lat_addr_r    <= alu_result_i;
            lat_wdata_r   <= mem_wdata_i;
            lat_we_r      <= mem_wen_i;
            lat_reg_wen_r <= reg_wen_i;
            lat_waddr_r   <= reg_waddr_i;
            lat_wb_sel_r  <= wb_sel_i;
            lat_pc_r      <= pc_i;
            lat_pc4_r     <= pc4_i;
        end
    end

    mem_wb_sel #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) u_wb_sel (
        .wb_sel     (mux_sel_s),
        .alu_result (mux_alu_s),
        .rdata      (dmem_rdata_i),
        .pc4        (mux_pc4_s),
        .wb_data    (mux_data_s)
    );

    // Write-back record register; fields are zeroed when no record retires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_r      <= 1'b0;
            reg_wen_out_r   <= 1'b0;
            reg_waddr_out_r <= 5'd0;
            wb_data_r       <= '0;
            pc_out_r        <= '0;
            misalign_r      <= 1'b0;
        end else if (rec_valid_s) begin
            wb_valid_r      <= 1'b1;
            reg_wen_out_r   <= rec_reg_wen_s;
            reg_waddr_out_r <= rec_waddr_s;
            wb_data_r       <= mux_data_s;
            pc_out_r        <= rec_pc_s;
            misalign_r      <= rec_misalign_s;
        end else begin
            wb_valid_r      <= 1'b0;
            reg_wen_out_r   <= 1'b0;
            reg_waddr_out_r <= 5'd0;
            wb_data_r       <= '0;
            pc_out_r        <= '0;
            misalign_r      <= 1'b0;
        end
    end

    assign pause_o      = pause_s;
    assign dmem_req_o   = (state_r == MEM_REQ);
    assign dmem_we_o    = (state_r == MEM_REQ) & lat_we_r;
    assign dmem_addr_o  = {lat_addr_r[DATA_W-1:2], 2'b00};
    assign dmem_wdata_o = lat_wdata_r;

    assign wb_valid_o   = wb_valid_r;
    assign reg_wen_o    = reg_wen_out_r;
    assign reg_waddr_o  = reg_waddr_out_r;
    assign wb_data_o    = wb_data_r;
    assign pc_o         = pc_out_r;
    assign misalign_o   = misalign_r;

endmodule

// File: doc/mem_access.md
# mem_access

MEM-stage data-memory access unit; consumes the EX/MEM pipeline register outputs and issues loads and stores on the data-memory request/response bus. It stalls the front of the pipeline while a bus access is outstanding and presents a registered write-back record to MEM/WB. The EX/MEM register flushes to a bubble while paused, so this block captures the whole instruction on acceptance and works only from its own copy afterwards.

## Interface
- DATA_W, 32: data word width; matches `WordBus`.
- PC_W, 16: PC width.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- inst_valid_i  in  1  valid instruction from EX/MEM.
- mem_wen_i  in  1  store.
- mem_wdata_i  in  DATA_W  store data.
- reg_wen_i  in  1  register write enable.
- reg_waddr_i  in  5  destination register (`RegAddrBus`).
- alu_result_i  in  DATA_W  memory byte address, or ALU write-back value.
- wb_sel_i  in  2  write-back source.
- pc_i, pc4_i  in  PC_W  instruction PC and PC+4.
- pause_o  out  1  stall request to PC/IF/ID/EX and EX/MEM.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  write strobe.
- dmem_addr_o  out  DATA_W  word-aligned address.
- dmem_wdata_o  out  DATA_W  write data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  DATA_W  read data.
- wb_valid_o, reg_wen_o  out  1  write-back record valid; register write enable.
- reg_waddr_o  out  5  destination register.
- wb_data_o  out  DATA_W  write-back value.
- pc_o  out  PC_W  PC of the retiring instruction.
- misalign_o  out  1  one-cycle flag: memory operation with `addr[1:0]` not equal to 0.

## Operation
- Memory operation (memop) = `inst_valid_i & (mem_wen_i | wb_sel_i==WB_FROM_MEM)`.
- FSM states: IDLE, REQ, RESP.
- IDLE, memop, aligned address:
  - Latch address, store data, we, reg_wen, waddr, wb_sel, pc, pc4.
  - Go to REQ.
- IDLE, memop, misaligned address:
  - No bus access.
  - Next cycle: wb_valid_o=1, reg_wen_o=0, misalign_o=1.
  - Stay in IDLE.
- IDLE, non-memop:
  - Next cycle: wb_valid_o=inst_valid_i, reg_wen_o=reg_wen_i & inst_valid_i.
  - wb_data_o = pc4 zero-extended when wb_sel is WB_FROM_PC4; otherwise alu_result.
- REQ:
  - dmem_req_o=1; we, addr and wdata come from the latched copy.
  - Hold all bus outputs stable until dmem_gnt_i.
  - On gnt: a store completes; a load goes to RESP.
- RESP: wait for dmem_rvalid_i; the load completes with wb_data = dmem_rdata_i.
- Completion: the registered record is written out at the next edge, and the FSM returns to IDLE.
- pause_o is combinational:
  - 1 in IDLE when a memop with an aligned address is present.
  - 1 in REQ until gnt (store) or until rvalid (load).
  - 1 in RESP until rvalid.
  - 0 in the completion cycle, so upstream advances on the same edge that the record retires.
- dmem_addr_o = {addr[DATA_W-1:2], 2'b00}.
- dmem_rvalid_i is ignored outside RESP. dmem_gnt_i is ignored outside REQ.
- Reset (asynchronous assertion, including mid-access):
  - FSM goes to IDLE.
  - All outputs are 0; wb_data_o and pc_o are 0.
  - A late rvalid from the aborted access is dropped.

## Timing
- Non-memop: accepted in cycle N, record valid in N+1, no stall.
- Store: accepted in N; dmem_req_o high from N+1; gnt in cycle G; record in G+1. Stall cycles = G−N.
- Load: gnt in G; rvalid in R ≥ G+1; record in R+1.
  - Minimum load: accept N, req N+1, gnt N+1, rvalid N+2, record N+3. This gives 2 stall cycles.
- rvalid in the same cycle as gnt is a protocol violation. The design ignores it, because the FSM is not yet in RESP.
- wb_valid_o is a one-cycle pulse per retired instruction. It is never high for two cycles on behalf of one instruction.

## Structure
- Add `WB_FROM_NOP`=0, `WB_FROM_ALU`=1, `WB_FROM_MEM`=2 and `WB_FROM_PC4`=3 to defines.vh.
- Add FSM state encodings `MEM_IDLE`, `MEM_REQ` and `MEM_RESP` to defines.vh.
- One sub-module, `mem_wb_sel`: a combinational write-back source mux (alu / rdata / pc4 / zero).
- FSM, latch registers and output registers live in `mem_access`.

## Test plan
- Non-memop, wb_sel=ALU, alu_result=0x1234, waddr=3:
  - Next cycle: wb_valid_o=1, wb_data_o=0x1234, reg_waddr_o=3.
  - pause_o stays 0.
- Store, addr=0x40, data=0xDEADBEEF, gnt after 3 cycles:
  - dmem_req_o held 3 cycles with addr=0x40 and we=1.
  - pause_o is high 3 cycles.
  - Record in the cycle after gnt with reg_wen_o=0.
- Load, addr=0x80, gnt immediate, rvalid 2 cycles later with 0x55AA:
  - wb_data_o=0x55AA, reg_wen_o=1.
  - pause_o low in the rvalid cycle.
- Misaligned load, addr=0x82:
  - No dmem_req_o.
  - misalign_o=1 and reg_wen_o=0 for one cycle.
- Reset pulled low while in RESP, then rvalid arrives after reset is released:
  - All outputs stay 0.
  - No wb_valid_o pulse.
- Back-to-back: load, then ALU op presented during the stall:
  - The ALU op retires in the cycle after the load record.
  - Order is preserved and no record is duplicated.
